// File: rtl/ublock_ti_pkg.sv
// Shared constants, share-pair payload type and the F/G decomposition tables for the TI S-box layer.
package ublock_ti_pkg;

  localparam int unsigned SBOX_W   = 4;
  localparam int unsigned N_SHARES = 2;
  localparam int unsigned GUARD_W  = 4;
  localparam int unsigned N_MONO   = 1 << SBOX_W;

  // One nibble in two shares
  typedef struct packed {
    logic [SBOX_W-1:0] s1;
    logic [SBOX_W-1:0] s0;
  } nib_shares_t;

  // Per-output-bit ANF coefficient vectors (bit m set -> monomial with variable mask m present)
  typedef logic [SBOX_W-1:0][N_MONO-1:0] anf_t;

  // uBlock S-box truth table, entry x at index x
  localparam logic [N_MONO-1:0][SBOX_W-1:0] SBOX_LUT = {
    4'h5, 4'h2, 4'h3, 4'h0, 4'h6, 4'h1, 4'hE, 4'hF,
    4'h8, 4'hD, 4'hA, 4'hB, 4'hC, 4'h9, 4'h4, 4'h7
  };

  // Unshared reference S-box
  function automatic logic [SBOX_W-1:0] sbox_ref(input logic [SBOX_W-1:0] x);
    return SBOX_LUT[x];
  endfunction

  // Quadratic Toffoli-style first stage; it is an involution, so S = G o F with G = S o F
  function automatic logic [SBOX_W-1:0] f_map(input logic [SBOX_W-1:0] x);
    return {x[3] ^ (x[2] & x[1]), x[2:0]};
  endfunction

  // Second stage completes the S-box
  function automatic logic [SBOX_W-1:0] g_map(input logic [SBOX_W-1:0] y);
    return SBOX_LUT[f_map(y)];
  endfunction

  // Moebius transform of a stage's truth table into its ANF
  function automatic anf_t anf_of(input logic stage_g);
    anf_t              c;
    logic [SBOX_W-1:0] v;
    c = '0;
    for (int m = 0; m < int'(N_MONO); m++) begin
      for (int s = 0; s < int'(N_MONO); s++) begin
        if ((s & ~m) == 0) begin
          v = stage_g ? g_map(SBOX_W'(s)) : f_map(SBOX_W'(s));
          for (int b = 0; b < int'(SBOX_W); b++) begin
            c[b][m] = c[b][m] ^ v[b];
          end
        end
      end
    end
    return c;
  endfunction

  localparam anf_t F_ANF = anf_of(1'b0);
  localparam anf_t G_ANF = anf_of(1'b1);

  // Evaluate an ANF on a 2-share input: every monomial is expanded into its
  // share-product terms; the all-share1 term goes to share 1, all others to share 0.
  // The unmasked value is never formed.
  function automatic nib_shares_t shared_eval(input anf_t             anf,
                                              input logic [SBOX_W-1:0] x0,
                                              input logic [SBOX_W-1:0] x1);
    nib_shares_t r;
    logic        term;
    r = '0;
    for (int b = 0; b < int'(SBOX_W); b++) begin
      for (int m = 0; m < int'(N_MONO); m++) begin
        if (anf[b][m]) begin
          if (m == 0) begin
            r.s0[b] = ~r.s0[b];
          end else begin
            for (int s = 0; s < int'(N_MONO); s++) begin
              if ((s & ~m) == 0) begin
                term = 1'b1;
                for (int k = 0; k < int'(SBOX_W); k++) begin
                  if (m[k]) term = term & (s[k] ? x1[k] : x0[k]);
                end
                if (s == m) r.s1[b] = r.s1[b] ^ term;
                else        r.s0[b] = r.s0[b] ^ term;
              end
            end
          end
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/shared_sbox_nibble.sv
// One 2-share F->G decomposed S-box: stage F registers re-masked F shares and
// the G guards, stage G registers re-masked G shares. en_i freezes every register.
module shared_sbox_nibble
  import ublock_ti_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic [SBOX_W-1:0] a0_i,
  input  logic [SBOX_W-1:0] a1_i,
  input  logic [1:0]        gf_i,
  input  logic [1:0]        gg_i,
  output logic [SBOX_W-1:0] y0_o,
  output logic [SBOX_W-1:0] y1_o
);

  nib_shares_t       f_sh_c;
  nib_shares_t       g_sh_c;
  logic [SBOX_W-1:0] f0_d, f1_d, f0_q, f1_q;
  logic [1:0]        gg_d, gg_q;
  logic [SBOX_W-1:0] y0_d, y1_d, y0_q, y1_q;

  // Shared F on the input, then shared G on the stage-F registers; guards re-mask both shares equally
  always_comb begin
    f_sh_c = shared_eval(F_ANF, a0_i, a1_i);
    f0_d   = f_sh_c.s0 ^ {gf_i, gf_i};
    f1_d   = f_sh_c.s1 ^ {gf_i, gf_i};
    gg_d   = gg_i;
    g_sh_c = shared_eval(G_ANF, f0_q, f1_q);
    y0_d   = g_sh_c.s0 ^ {gg_q, gg_q};
    y1_d   = g_sh_c.s1 ^ {gg_q, gg_q};
  end

  // Pipeline registers, held while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f0_q <= '0;
      f1_q <= '0;
      gg_q <= '0;
      y0_q <= '0;
      y1_q <= '0;
    end else if (en_i) begin
      f0_q <= f0_d;
      f1_q <= f1_d;
      gg_q <= gg_d;
      y0_q <= y0_d;
      y1_q <= y1_d;
    end
  end

  assign y0_o = y0_q;
  assign y1_o = y1_q;

endmodule

// File: rtl/shared_sbox_layer.sv
// Parallel layer of 2-share TI S-boxes with valid/ready handshake, whole-pipeline
// stall and selectable guard source (external or neighbour chain).
module shared_sbox_layer
  import ublock_ti_pkg::*;
#(
  parameter int unsigned NUM_SBOX   = 32,
  parameter int unsigned GUARD_MODE = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [SBOX_W*NUM_SBOX-1:0] in_share0,
  input  logic [SBOX_W*NUM_SBOX-1:0] in_share1,
  input  logic [SBOX_W*NUM_SBOX-1:0] guards_ext,
  input  logic [GUARD_W-1:0]         guard_seed,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [SBOX_W*NUM_SBOX-1:0] out_share0,
  output logic [SBOX_W*NUM_SBOX-1:0] out_share1
);

  logic v1_d, v1_q, v2_d, v2_q;
  logic stall_c;
  logic unused_guards;

  // Only one guard source is consumed per configuration
  assign unused_guards = ^{guards_ext, guard_seed};

  // Stall and valid-flag advance
  always_comb begin
    stall_c  = v2_q & ~out_ready;
    in_ready = ~stall_c;
    v1_d     = v1_q;
    v2_d     = v2_q;
    if (!stall_c) begin
      v1_d = in_valid;
      v2_d = v1_q;
    end
  end

  // Valid flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
    end
  end

  assign out_valid = v2_q;

  // Guard routing and S-box instances
  for (genvar i = 0; i < int'(NUM_SBOX); i++) begin : g_sbox
    logic [GUARD_W-1:0] guard_c;

    if (GUARD_MODE == 0) begin : g_ext
      assign guard_c = guards_ext[GUARD_W*i +: GUARD_W];
    end else if (i < int'(NUM_SBOX) - 1) begin : g_chain
      assign guard_c = in_share0[SBOX_W*(i+1) +: SBOX_W];
    end else begin : g_seed
      assign guard_c = guard_seed;
    end

    shared_sbox_nibble u_nibble (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (~stall_c),
      .a0_i  (in_share0[SBOX_W*i +: SBOX_W]),
      .a1_i  (in_share1[SBOX_W*i +: SBOX_W]),
      .gf_i  (guard_c[3:2]),
      .gg_i  (guard_c[1:0]),
      .y0_o  (out_share0[SBOX_W*i +: SBOX_W]),
      .y1_o  (out_share1[SBOX_W*i +: SBOX_W])
    );
  end

endmodule

// File: tb/tb_shared_sbox_layer.sv
// Bench for shared_sbox_layer: single-nibble table, exhaustive/random streams,
// backpressure, neighbour-chain guards and mid-stream reset.
module tb_shared_sbox_layer;

  localparam int unsigned N = 32;
  localparam int unsigned W = 4 * N;

  localparam logic [3:0] SB [16] = '{4'h7, 4'h4, 4'h9, 4'hC, 4'hB, 4'hA, 4'hD, 4'h8,
                                     4'hF, 4'hE, 4'h1, 4'h6, 4'h0, 4'h3, 4'h2, 4'h5};

  logic clk, rst_n;

  // Shared stimulus for the mode-0 and mode-1 wide instances
  logic         in_valid, out_ready;
  logic [W-1:0] in_s0, in_s1, gext;
  logic [3:0]   seed;
  logic         in_ready_a, out_valid_a, in_ready_g, out_valid_g;
  logic [W-1:0] o0_a, o1_a, o0_g, o1_g;

  // Single-nibble instance
  logic       in_valid1, out_ready1, in_ready1, out_valid1;
  logic [3:0] in1_s0, in1_s1, gext1, seed1, o0_1, o1_1;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q [$];

  shared_sbox_layer #(.NUM_SBOX(N), .GUARD_MODE(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_share0(in_s0), .in_share1(in_s1), .guards_ext(gext), .guard_seed(seed),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_share0(o0_a), .out_share1(o1_a));

  shared_sbox_layer #(.NUM_SBOX(N), .GUARD_MODE(1)) dut_g (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_g),
    .in_share0(in_s0), .in_share1(in_s1), .guards_ext(gext), .guard_seed(seed),
    .out_valid(out_valid_g), .out_ready(out_ready), .out_share0(o0_g), .out_share1(o1_g));

  shared_sbox_layer #(.NUM_SBOX(1), .GUARD_MODE(0)) dut_1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_share0(in1_s0), .in_share1(in1_s1), .guards_ext(gext1), .guard_seed(seed1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_share0(o0_1), .out_share1(o1_1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: S applied to every nibble of the unmasked state
  function automatic logic [W-1:0] model(input logic [W-1:0] x);
    logic [W-1:0] r;
    for (int i = 0; i < int'(N); i++) r[4*i +: 4] = SB[x[4*i +: 4]];
    return r;
  endfunction

  function automatic logic [W-1:0] rnd_w();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle on the wide pair: drive at negedge, score output handshake, record accepts
  task automatic step(input logic iv, input logic [W-1:0] s0, input logic [W-1:0] s1,
                      input logic [W-1:0] g, input logic [3:0] sd, input logic ordy,
                      output logic acc);
    logic [W-1:0] e;
    @(negedge clk);
    in_valid = iv; in_s0 = s0; in_s1 = s1; gext = g; seed = sd; out_ready = ordy;
    #1;
    check("valid_g_vs_a", W'(out_valid_g), W'(out_valid_a));
    if (out_valid_a && ordy) begin
      if (exp_q.size() == 0) begin
        check("spurious_output", W'(out_valid_a), W'(0));
      end else begin
        e = exp_q.pop_front();
        check("unmask_mode0", o0_a ^ o1_a, e);
        check("unmask_mode1", o0_g ^ o1_g, e);
      end
    end
    acc = iv && in_ready_a;
    if (acc) exp_q.push_back(model(s0 ^ s1));
  endtask

  task automatic idle(input logic ordy);
    logic acc;
    step(1'b0, rnd_w(), rnd_w(), rnd_w(), 4'($urandom), ordy, acc);
  endtask

  task automatic drain(input string name);
    repeat (6) idle(1'b1);
    check(name, W'(exp_q.size()), W'(0));
  endtask

  typedef struct {
    logic [3:0] s0;
    logic [3:0] s1;
    logic [3:0] g;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl [10];

  initial begin
    logic         acc;
    logic [W-1:0] x, s0, snap0, snap1;

    tbl[0] = '{4'h3, 4'h3, 4'hA, 4'h7};
    tbl[1] = '{4'h0, 4'h1, 4'h5, 4'h4};
    tbl[2] = '{4'hF, 4'h0, 4'h0, 4'h5};
    tbl[3] = '{4'h5, 4'hA, 4'h3, 4'h5};
    tbl[4] = '{4'h6, 4'h2, 4'h0, 4'hB};
    tbl[5] = '{4'h9, 4'h1, 4'hC, 4'hF};
    tbl[6] = '{4'hC, 4'h0, 4'hF, 4'h0};
    tbl[7] = '{4'h7, 4'h0, 4'h6, 4'h8};
    tbl[8] = '{4'h2, 4'h8, 4'h9, 4'h1};
    tbl[9] = '{4'h6, 4'h3, 4'h1, 4'hA};

    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1; in_s0 = '0; in_s1 = '0; gext = '0; seed = '0;
    in_valid1 = 1'b0; out_ready1 = 1'b1; in1_s0 = '0; in1_s1 = '0; gext1 = '0; seed1 = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Reset state
    check("rst_valid_a", W'(out_valid_a), W'(0));
    check("rst_share0_a", o0_a, '0);
    check("rst_share1_a", o1_a, '0);
    check("rst_ready_a", W'(in_ready_a), W'(1));
    check("rst_share0_g", o0_g, '0);
    check("rst_valid_1", W'(out_valid1), W'(0));
    check("rst_ready_1", W'(in_ready1), W'(1));

    // Single-nibble table: one valid, result exactly 2 cycles later for one cycle
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      in_valid1 = 1'b1; in1_s0 = tbl[t].s0; in1_s1 = tbl[t].s1; gext1 = tbl[t].g;
      #1 check("nib_ready", W'(in_ready1), W'(1));
      @(negedge clk);
      in_valid1 = 1'b0; in1_s0 = 4'($urandom); in1_s1 = 4'($urandom);
      #1 check("nib_valid_lat1", W'(out_valid1), W'(0));
      @(negedge clk);
      #1 check("nib_valid_lat2", W'(out_valid1), W'(1));
      check("nib_unmask", W'(o0_1 ^ o1_1), W'(tbl[t].exp));
      @(negedge clk);
      #1 check("nib_valid_once", W'(out_valid1), W'(0));
    end

    // Exhaustive back-to-back: every nibble value under random splits and guards
    for (int k = 0; k < 256; k++) begin
      for (int i = 0; i < int'(N); i++) x[4*i +: 4] = 4'(k + i);
      s0 = rnd_w();
      step(1'b1, s0, s0 ^ x, rnd_w(), 4'($urandom), 1'b1, acc);
      check("b2b_accept", W'(acc), W'(1));
      if (k >= 2) check("b2b_throughput", W'(out_valid_a), W'(1));
    end
    drain("b2b_drain");

    // Random valid/ready traffic
    for (int k = 0; k < 300; k++) begin
      step(($urandom % 4) != 0, rnd_w(), rnd_w(), rnd_w(), 4'($urandom),
           ($urandom % 3) != 0, acc);
    end
    drain("rand_drain");

    // Backpressure: two items fill the pipe, a third waits, 5 stalled cycles
    step(1'b1, rnd_w(), rnd_w(), rnd_w(), 4'($urandom), 1'b0, acc);
    step(1'b1, rnd_w(), rnd_w(), rnd_w(), 4'($urandom), 1'b0, acc);
    s0 = rnd_w(); x = rnd_w();
    for (int c = 0; c < 5; c++) begin
      step(1'b1, s0, x, rnd_w(), 4'($urandom), 1'b0, acc);
      if (c == 0) begin snap0 = o0_a; snap1 = o1_a; end
      check("bp_in_ready", W'(in_ready_a), W'(0));
      check("bp_out_valid", W'(out_valid_a), W'(1));
      check("bp_hold_share0", o0_a, snap0);
      check("bp_hold_share1", o1_a, snap1);
    end
    step(1'b1, s0, x, rnd_w(), 4'($urandom), 1'b1, acc);
    check("bp_release_accept", W'(acc), W'(1));
    drain("bp_drain");

    // Neighbour-chain guards: seed 5, share0 nibble i = i, external guards zero
    for (int i = 0; i < int'(N); i++) s0[4*i +: 4] = 4'(i);
    step(1'b1, s0, rnd_w(), '0, 4'h5, 1'b1, acc);
    idle(1'b1);
    idle(1'b1);
    n_vec++;
    if (o0_g === o0_a) begin
      n_err++;
      $display("FAIL chain_remask: mode1 share0 %h equals mode0 share0 %h", o0_g, o0_a);
    end
    drain("chain_drain");

    // Reset with both stages occupied
    step(1'b1, rnd_w(), rnd_w(), rnd_w(), 4'($urandom), 1'b1, acc);
    step(1'b1, rnd_w(), rnd_w(), rnd_w(), 4'($urandom), 1'b1, acc);
    @(negedge clk);
    in_valid = 1'b0;
    #1 check("pre_rst_valid", W'(out_valid_a), W'(1));
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid_a", W'(out_valid_a), W'(0));
    check("mid_rst_valid_g", W'(out_valid_g), W'(0));
    check("mid_rst_share0", o0_a, '0);
    check("mid_rst_ready", W'(in_ready_a), W'(1));
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, rnd_w(), rnd_w(), rnd_w(), 4'($urandom), 1'b1, acc);
    check("post_rst_accept", W'(acc), W'(1));
    idle(1'b1);
    check("post_rst_lat1", W'(out_valid_a), W'(0));
    idle(1'b1);
    check("post_rst_lat2", W'(out_valid_a), W'(1));
    drain("post_rst_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
